operand_entry: RTL



---
 rtl/operand_entry_pkg.sv | 20 ++
 rtl/operand_entry_digit_accum.sv | 27 ++
 rtl/operand_entry.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/operand_entry_pkg.sv
// rtl/operand_entry_pkg.sv - shared key codes, state encoding and operand width
package operand_entry_pkg;

  localparam int OP_W = 9;

  localparam logic [3:0] KEY_NEG    = 4'd10;
  localparam logic [3:0] KEY_CLR    = 4'd11;
  localparam logic [3:0] KEY_STORE  = 4'd12;
  localparam logic [3:0] KEY_RECALL = 4'd13;

  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    WAIT_WR = 3'd1,
    WRITE   = 3'd2,
    WAIT_RD = 3'd3,
    READ    = 3'd4,
    LOAD    = 3'd5
  } state_t;

endpackage

// File: rtl/operand_entry_digit_accum.sv
// rtl/operand_entry_digit_accum.sv - decimal digit accumulate with range and count checks
module digit_accum #(
  parameter int MAX_DIGITS = 3,
  parameter int MAX_MAG    = 255
) (
  input  logic [8:0] mag_i,
  input  logic [3:0] d_i,
  input  logic [1:0] digit_cnt_i,
  output logic [8:0] next_mag_o,
  output logic       ok_o
);

  localparam logic [12:0] MAX_MAG_W  = 13'(MAX_MAG);
  localparam logic [2:0]  MAX_DIG_W  = 3'(MAX_DIGITS);

  logic [12:0] mag_w;
  logic [12:0] times10;
  logic [12:0] sum;

  // Full 13-bit width so a recalled 256 times ten still compares correctly.
  assign mag_w      = {4'b0000, mag_i};
  assign times10    = (mag_w << 3) + (mag_w << 1);
  assign sum        = times10 + {9'd0, d_i};
  assign next_mag_o = sum[8:0];
  assign ok_o       = ({1'b0, digit_cnt_i} < MAX_DIG_W) && (sum <= MAX_MAG_W);

endmodule

// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - keypad operand entry with STORE/RECALL register-file transactions
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int NREG       = 4,
  parameter int MAX_DIGITS = 3,
  parameter int MAX_MAG    = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_valid,
  input  logic [3:0]      key_code,
  input  logic [OP_W-1:0] reg_val,
  output logic [OP_W-1:0] op1,
  output logic [2:0]      reg_num,
  output logic [2:0]      reg_sel,
  output logic            neg,
  output logic [1:0]      digit_cnt,
  output logic            busy,
  output logic            err
);

  localparam logic [3:0]      NREG_K    = 4'(NREG);
  localparam logic [OP_W-1:0] MAX_MAG_K = OP_W'(MAX_MAG);

  state_t          state_q, state_d;
  logic [OP_W-1:0] mag_q, mag_d;
  logic            neg_q, neg_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [2:0]      target_q, target_d;

  logic [OP_W-1:0] acc_mag;
  logic            acc_ok;
  logic            is_digit;
  logic            is_target;

  digit_accum #(
    .MAX_DIGITS (MAX_DIGITS),
    .MAX_MAG    (MAX_MAG)
  ) u_digit_accum (
    .mag_i       (mag_q),
    .d_i         (key_code),
    .digit_cnt_i (cnt_q),
    .next_mag_o  (acc_mag),
    .ok_o        (acc_ok)
  );

  assign is_digit  = (key_code <= 4'd9);
  assign is_target = (key_code >= 4'd1) && (key_code <= NREG_K);

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    target_d = target_q;
    case (state_q)
      ENTRY: begin
        if (key_valid) begin
          if (is_digit) begin
            if (acc_ok) begin
              mag_d = acc_mag;
              cnt_d = cnt_q + 2'd1;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_code == KEY_NEG) begin
            if (mag_q <= MAX_MAG_K) neg_d = ~neg_q;
            else                    err_d = 1'b1;
          end else if (key_code == KEY_CLR) begin
            mag_d = '0;
            neg_d = 1'b0;
            cnt_d = 2'd0;
            err_d = 1'b0;
          end else if (key_code == KEY_STORE) begin
            state_d = WAIT_WR;
          end else if (key_code == KEY_RECALL) begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_WR, WAIT_RD: begin
        if (key_valid) begin
          if (is_target) begin
            target_d = key_code[2:0];
            state_d  = (state_q == WAIT_WR) ? WRITE : READ;
          end else if (is_digit) begin
            err_d   = 1'b1;
            state_d = ENTRY;
          end else if (key_code == KEY_CLR) begin
            mag_d   = '0;
            neg_d   = 1'b0;
            cnt_d   = 2'd0;
            err_d   = 1'b0;
            state_d = ENTRY;
          end
        end
      end
      WRITE: begin
        mag_d   = '0;
        neg_d   = 1'b0;
        cnt_d   = 2'd0;
        state_d = ENTRY;
      end
      READ: state_d = LOAD;
      LOAD: begin
        // Two's-complement magnitude; -256 maps to 256, which still fits 9 bits unsigned.
        neg_d   = reg_val[OP_W-1];
        mag_d   = reg_val[OP_W-1] ? (~reg_val + OP_W'(1)) : reg_val;
        cnt_d   = 2'd0;
        state_d = ENTRY;
      end
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ENTRY;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= 2'd0;
      err_q    <= 1'b0;
      target_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      target_q <= target_d;
    end
  end

  assign op1       = neg_q ? (~mag_q + OP_W'(1)) : mag_q;
  assign reg_num   = (state_q == WRITE) ? target_q : 3'd0;
  assign reg_sel   = (state_q == READ)  ? target_q : 3'd0;
  assign neg       = neg_q;
  assign digit_cnt = cnt_q;
  assign err       = err_q;
  assign busy      = (state_q == WRITE) || (state_q == READ) || (state_q == LOAD);

endmodule
